// File: rtl/array_heap.sv
// Command-driven array allocator/heap (LIFO id reuse, bounds checks); ARRAY_HEAP_CLEAR_ON_ALLOC_EN zero-fills new areas.
// Latency: IDLE->EXEC->RESP, one command per 3 cycles; a clearing ALLOC adds N_AREA CLEAR cycles.
// Backpressure: cmd_ready is high only in IDLE; responses are one-cycle pulses with no back-pressure.
module array_heap #(
    parameter int WIDTH    = 12,
    parameter int N_AREA   = 10,
    parameter int N_ARRAYS = 16,
    parameter int AW       = (N_ARRAYS > 1) ? $clog2(N_ARRAYS) : 1,
    parameter int IW       = $clog2(N_AREA + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_array,
    input  logic [IW-1:0]    cmd_index,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_error,
    output logic [AW:0]      in_use,
    output logic [AW:0]      high_water
);
    localparam int DEPTH = N_ARRAYS * N_AREA;
    localparam int HAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_ALLOC = 3'd0, OP_FREE = 3'd1, OP_PUSH = 3'd2, OP_POP = 3'd3,
                           OP_SIZE  = 3'd4, OP_READ = 3'd5, OP_WRITE = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP, S_CLEAR} state_t;

    typedef struct packed {
        logic [2:0]       op;
        logic [AW-1:0]    array;
        logic [IW-1:0]    index;
        logic [WIDTH-1:0] data;
    } cmd_t;

    state_t           state, state_nxt;
    cmd_t             cmd_q;
    logic [IW-1:0]    sizes      [N_ARRAYS];
    logic [AW-1:0]    free_stack [N_ARRAYS];
    logic [N_ARRAYS-1:0] allocated;
    logic [AW:0]      free_cnt, next_new, free_top;
    logic [WIDTH-1:0] heap [DEPTH];

`ifdef ARRAY_HEAP_CLEAR_ON_ALLOC_EN
    logic [IW-1:0]    clr_cnt;
    logic [AW-1:0]    clr_id;
`endif

    logic             id_ok, have_free, alloc_ok, exec_err, hw_en, size_en;
    logic [IW-1:0]    cur_size, size_val;
    logic [AW-1:0]    alloc_id;
    logic [WIDTH-1:0] exec_rsp;
    logic [HAW-1:0]   hw_addr, rd_addr;

    // Full-width base+offset so an index never spills into the neighbouring area.
    function automatic logic [HAW-1:0] addr_of(input logic [AW-1:0] id, input logic [IW-1:0] off);
        return HAW'(int'(id) * N_AREA + int'(off));
    endfunction

    always_comb begin
        id_ok     = (int'(cmd_q.array) < N_ARRAYS) && allocated[cmd_q.array];
        cur_size  = sizes[cmd_q.array];
        have_free = (free_cnt != '0);
        free_top  = free_cnt - 1'b1;
        alloc_id  = have_free ? free_stack[free_top[AW-1:0]] : next_new[AW-1:0];
        alloc_ok  = have_free || (int'(next_new) < N_ARRAYS);
        exec_err  = 1'b0;
        exec_rsp  = '0;
        hw_en     = 1'b0;
        hw_addr   = '0;
        rd_addr   = '0;
        size_en   = 1'b0;
        size_val  = cur_size;
        case (cmd_q.op)
            OP_ALLOC: begin
                exec_err = !alloc_ok;
                exec_rsp = WIDTH'(alloc_id);
            end
            OP_FREE: exec_err = !id_ok;
            OP_PUSH: begin
                exec_err = !id_ok || (cur_size == IW'(N_AREA));
                hw_en    = 1'b1;
                hw_addr  = addr_of(cmd_q.array, cur_size);
                size_en  = 1'b1;
                size_val = cur_size + 1'b1;
                exec_rsp = WIDTH'(size_val);
            end
            OP_POP: begin
                exec_err = !id_ok || (cur_size == '0);
                rd_addr  = addr_of(cmd_q.array, cur_size - 1'b1);
                size_en  = 1'b1;
                size_val = cur_size - 1'b1;
                exec_rsp = heap[rd_addr];
            end
            OP_SIZE: begin
                exec_err = !id_ok;
                exec_rsp = WIDTH'(cur_size);
            end
            OP_READ: begin
                exec_err = !id_ok || (cmd_q.index >= cur_size);
                rd_addr  = addr_of(cmd_q.array, cmd_q.index);
                exec_rsp = heap[rd_addr];
            end
            OP_WRITE: begin
                exec_err = !id_ok || (int'(cmd_q.index) >= N_AREA);
                hw_en    = 1'b1;
                hw_addr  = addr_of(cmd_q.array, cmd_q.index);
                size_en  = 1'b1;
                size_val = (cmd_q.index >= cur_size) ? cmd_q.index + 1'b1 : cur_size;
            end
            default: exec_err = 1'b1;
        endcase
        if (exec_err) begin
            exec_rsp = '0;
            hw_en    = 1'b0;
            size_en  = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = (state == S_IDLE);
        rsp_valid = (state == S_RESP);
        case (state)
            S_IDLE: if (cmd_valid) state_nxt = S_EXEC;
            S_EXEC: begin
                state_nxt = S_RESP;
`ifdef ARRAY_HEAP_CLEAR_ON_ALLOC_EN
                if (cmd_q.op == OP_ALLOC && !exec_err) state_nxt = S_CLEAR;
`endif
            end
`ifdef ARRAY_HEAP_CLEAR_ON_ALLOC_EN
            S_CLEAR: if (clr_cnt == IW'(N_AREA - 1)) state_nxt = S_RESP;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cmd_q      <= '0;
            allocated  <= '0;
            free_cnt   <= '0;
            next_new   <= '0;
            in_use     <= '0;
            high_water <= '0;
            rsp_data   <= '0;
            rsp_error  <= 1'b0;
            for (int i = 0; i < N_ARRAYS; i++) begin
                sizes[i]      <= '0;
                free_stack[i] <= '0;
            end
`ifdef ARRAY_HEAP_CLEAR_ON_ALLOC_EN
            clr_cnt    <= '0;
            clr_id     <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && cmd_valid)
                cmd_q <= '{op: cmd_op, array: cmd_array, index: cmd_index, data: cmd_data};
            if (state == S_EXEC) begin
                rsp_data  <= exec_rsp;
                rsp_error <= exec_err;
                if (size_en) sizes[cmd_q.array] <= size_val;
                if (!exec_err && cmd_q.op == OP_ALLOC) begin
                    if (have_free) free_cnt <= free_cnt - 1'b1;
                    else           next_new <= next_new + 1'b1;
                    allocated[alloc_id] <= 1'b1;
                    sizes[alloc_id]     <= '0;
                    in_use              <= in_use + 1'b1;
                    if (in_use + 1'b1 > high_water) high_water <= in_use + 1'b1;
`ifdef ARRAY_HEAP_CLEAR_ON_ALLOC_EN
                    clr_cnt <= '0;
                    clr_id  <= alloc_id;
`endif
                end
                if (!exec_err && cmd_q.op == OP_FREE) begin
                    free_stack[free_cnt[AW-1:0]] <= cmd_q.array;
                    free_cnt                     <= free_cnt + 1'b1;
                    allocated[cmd_q.array]       <= 1'b0;
                    in_use                       <= in_use - 1'b1;
                end
            end
`ifdef ARRAY_HEAP_CLEAR_ON_ALLOC_EN
            if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
`endif
        end
    end

    // Heap storage is deliberately not reset; an abandoned command must not write it either.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == S_EXEC && hw_en) heap[hw_addr] <= cmd_q.data;
`ifdef ARRAY_HEAP_CLEAR_ON_ALLOC_EN
            else if (state == S_CLEAR) heap[addr_of(clr_id, clr_cnt)] <= '0;
`endif
        end
    end
endmodule
